// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: byte/packet FSM
// state encodings, frame geometry, default timing parameters and parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    BS_IDLE   = 2'd0,
    BS_DATA   = 2'd1,
    BS_PARITY = 2'd2,
    BS_STOP   = 2'd3
  } byte_state_e;

  typedef enum logic [1:0] {
    PS_B0 = 2'd0,
    PS_B1 = 2'd1,
    PS_B2 = 2'd2
  } pkt_state_e;

  localparam int FRAME_BITS         = 11;
  localparam int DATA_BITS          = FRAME_BITS - 3;
  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ((^{data, par}) == 1'b1);
  endfunction

endpackage

// File: rtl/mouse_ps2_rx_chk.sv
// Protocol invariants of the mouse receiver, kept apart from the datapath.
module mouse_ps2_rx_chk (
  input logic clk,
  input logic rst_n,
  input logic err,
  input logic pkt_valid,
  input logic byte_valid,
  input logic byte_err
);

  a_out_excl: assert property (@(posedge clk) disable iff (!rst_n) !(err && pkt_valid));
  a_byte_excl: assert property (@(posedge clk) disable iff (!rst_n) !(byte_valid && byte_err));

endmodule

// File: rtl/ps2_byte_rx.sv
// PS/2 frame receiver: synchronises and debounces the device clock, samples
// data on filtered falling edges and delivers checked bytes or an error strobe.
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       byte_idle
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic          c_meta_r, c_sync_r, d_meta_r, d_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_r, filt_prev_r;
  logic          fall_s;

  byte_state_e   state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          par_r;
  logic [TW-1:0] tout_cnt_r;
  logic [7:0]    byte_r;
  logic          byte_valid_r, byte_err_r;

  // Synchronisers plus a level filter that only follows a stable clock line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_meta_r    <= 1'b1;
      c_sync_r    <= 1'b1;
      d_meta_r    <= 1'b1;
      d_sync_r    <= 1'b1;
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      c_meta_r    <= ps2c;
      c_sync_r    <= c_meta_r;
      d_meta_r    <= ps2d;
      d_sync_r    <= d_meta_r;
      filt_prev_r <= filt_r;
      if (c_sync_r != filt_r) begin
        if (filt_cnt_r == FILT_MAX) begin
          filt_r     <= c_sync_r;
          filt_cnt_r <= '0;
        end else begin
          filt_cnt_r <= filt_cnt_r + 1'b1;
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  assign fall_s = filt_prev_r & ~filt_r;

  // Byte FSM with in-frame timeout; an edge in the expiry cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= BS_IDLE;
      shift_r      <= 8'd0;
      bit_cnt_r    <= 3'd0;
      par_r        <= 1'b0;
      tout_cnt_r   <= '0;
      byte_r       <= 8'd0;
      byte_valid_r <= 1'b0;
      byte_err_r   <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      byte_err_r   <= 1'b0;
      if ((state_r != BS_IDLE) && !fall_s) begin
        if (tout_cnt_r == TOUT_MAX) begin
          state_r    <= BS_IDLE;
          byte_err_r <= 1'b1;
          tout_cnt_r <= '0;
        end else begin
          tout_cnt_r <= tout_cnt_r + 1'b1;
        end
      end else begin
        tout_cnt_r <= '0;
        if (fall_s) begin
          case (state_r)
            BS_IDLE: begin
              if (!d_sync_r) begin
                state_r   <= BS_DATA;
                bit_cnt_r <= 3'd0;
              end
            end
            BS_DATA: begin
              shift_r   <= {d_sync_r, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == LAST_BIT) begin
                state_r <= BS_PARITY;
              end
            end
            BS_PARITY: begin
              par_r   <= d_sync_r;
              state_r <= BS_STOP;
            end
            BS_STOP: begin
              if (d_sync_r && odd_parity_ok(shift_r, par_r)) begin
                byte_r       <= shift_r;
                byte_valid_r <= 1'b1;
              end else begin
                byte_err_r <= 1'b1;
              end
              state_r <= BS_IDLE;
            end
            default: state_r <= BS_IDLE;
          endcase
        end
      end
    end
  end

  assign rx_byte    = byte_r;
  assign byte_valid = byte_valid_r;
  assign byte_err   = byte_err_r;
  assign byte_idle  = (state_r == BS_IDLE);

endmodule

// File: rtl/mouse_ps2_rx.sv
// PS/2 mouse packet decoder: assembles three accepted bytes into button,
// motion and overflow outputs, with inter-byte timeout and error strobe.
module mouse_ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       pkt_valid,
  output logic       btn_l,
  output logic       btn_m,
  output logic       btn_r,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    rx_byte_s;
  logic          byte_valid_s, byte_err_s, byte_idle_s;

  pkt_state_e    pstate_r;
  logic [7:0]    b0_r, b1_r;
  logic [TW-1:0] ptout_r;
  logic          pkt_valid_r, err_r;
  logic          btn_l_r, btn_m_r, btn_r_r, x_ovf_r, y_ovf_r;
  logic [8:0]    dx_r, dy_r;

  ps2_byte_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_byte_rx (
    .clk        (CLK50MHZ),
    .rst_n      (RST),
    .ps2c       (PS2C),
    .ps2d       (PS2D),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .byte_err   (byte_err_s),
    .byte_idle  (byte_idle_s)
  );

  // Packet FSM; a byte error or inter-byte timeout drops any partial packet.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      pstate_r    <= PS_B0;
      b0_r        <= 8'd0;
      b1_r        <= 8'd0;
      ptout_r     <= '0;
      pkt_valid_r <= 1'b0;
      err_r       <= 1'b0;
      btn_l_r     <= 1'b0;
      btn_m_r     <= 1'b0;
      btn_r_r     <= 1'b0;
      x_ovf_r     <= 1'b0;
      y_ovf_r     <= 1'b0;
      dx_r        <= 9'd0;
      dy_r        <= 9'd0;
    end else begin
      pkt_valid_r <= 1'b0;
      err_r       <= 1'b0;
      if (byte_err_s) begin
        pstate_r <= PS_B0;
        err_r    <= 1'b1;
        ptout_r  <= '0;
      end else if (byte_valid_s) begin
        ptout_r <= '0;
        case (pstate_r)
          PS_B0: begin
            // Bit 3 of the first byte is always set; use it to resynchronise.
            if (rx_byte_s[3]) begin
              b0_r     <= rx_byte_s;
              pstate_r <= PS_B1;
            end else begin
              err_r <= 1'b1;
            end
          end
          PS_B1: begin
            b1_r     <= rx_byte_s;
            pstate_r <= PS_B2;
          end
          PS_B2: begin
            btn_l_r     <= b0_r[0];
            btn_r_r     <= b0_r[1];
            btn_m_r     <= b0_r[2];
            x_ovf_r     <= b0_r[6];
            y_ovf_r     <= b0_r[7];
            dx_r        <= {b0_r[4], b1_r};
            dy_r        <= {b0_r[5], rx_byte_s};
            pkt_valid_r <= 1'b1;
            pstate_r    <= PS_B0;
          end
          default: pstate_r <= PS_B0;
        endcase
      end else if ((pstate_r != PS_B0) && byte_idle_s) begin
        if (ptout_r == TOUT_MAX) begin
          pstate_r <= PS_B0;
          err_r    <= 1'b1;
          ptout_r  <= '0;
        end else begin
          ptout_r <= ptout_r + 1'b1;
        end
      end else begin
        ptout_r <= '0;
      end
    end
  end

  assign pkt_valid = pkt_valid_r;
  assign err       = err_r;
  assign btn_l     = btn_l_r;
  assign btn_m     = btn_m_r;
  assign btn_r     = btn_r_r;
  assign x_ovf     = x_ovf_r;
  assign y_ovf     = y_ovf_r;
  assign dx        = dx_r;
  assign dy        = dy_r;

  mouse_ps2_rx_chk u_chk (
    .clk        (CLK50MHZ),
    .rst_n      (RST),
    .err        (err_r),
    .pkt_valid  (pkt_valid_r),
    .byte_valid (byte_valid_s),
    .byte_err   (byte_err_s)
  );

endmodule

// File: tb/tb_mouse_ps2_rx.sv
// Self-checking bench for mouse_ps2_rx: directed scenarios plus random byte
// streams, scored against a packet-level reference model.
module tb_mouse_ps2_rx;

  localparam int FL = 4;
  localparam int TO = 400;

  logic       clk = 1'b0;
  logic       RST, PS2C, PS2D;
  logic       pkt_valid, btn_l, btn_m, btn_r, x_ovf, y_ovf, err;
  logic [8:0] dx, dy;

  mouse_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK50MHZ (clk),
    .RST      (RST),
    .PS2C     (PS2C),
    .PS2D     (PS2D),
    .pkt_valid(pkt_valid),
    .btn_l    (btn_l),
    .btn_m    (btn_m),
    .btn_r    (btn_r),
    .dx       (dx),
    .dy       (dy),
    .x_ovf    (x_ovf),
    .y_ovf    (y_ovf),
    .err      (err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_cnt = 0, pkt_cnt = 0, both_cnt = 0, err_cyc = 0;
  int last_fall_cyc = 0;

  logic [7:0] q[$];
  int   exp_err = 0, exp_pkt = 0;
  logic e_l = 1'b0, e_m = 1'b0, e_r = 1'b0, e_xo = 1'b0, e_yo = 1'b0;
  int   e_dx = 0, e_dy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (pkt_valid === 1'b1) pkt_cnt <= pkt_cnt + 1;
    if (err === 1'b1 && pkt_valid === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device-side frame: start, 8 data LSB first, odd parity, stop; nbits may truncate.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = data;
    fr[9]   = ~(^data) ^ bad_par;
    fr[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      PS2D = fr[i];
      cycles(20);
      PS2C = 1'b0;
      last_fall_cyc = cyc;
      cycles(40);
      PS2C = 1'b1;
      cycles(20);
    end
    PS2D = 1'b1;
  endtask

  // Reference: accepted bytes collect in a queue; three make a packet.
  task automatic model_byte(input logic [7:0] data, input bit accepted);
    if (!accepted) begin
      exp_err++;
      q.delete();
    end else if (q.size() == 0 && data[3] == 1'b0) begin
      exp_err++;
    end else begin
      q.push_back(data);
      if (q.size() == 3) begin
        exp_pkt++;
        e_l  = q[0][0];
        e_r  = q[0][1];
        e_m  = q[0][2];
        e_xo = q[0][6];
        e_yo = q[0][7];
        e_dx = (q[0][4] ? -256 : 0) + int'(q[1]);
        e_dy = (q[0][5] ? -256 : 0) + int'(q[2]);
        q.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":errs"}, err_cnt, exp_err);
    chk({tag, ":pkts"}, pkt_cnt, exp_pkt);
    chk({tag, ":btn_l"}, {31'd0, btn_l}, {31'd0, e_l});
    chk({tag, ":btn_m"}, {31'd0, btn_m}, {31'd0, e_m});
    chk({tag, ":btn_r"}, {31'd0, btn_r}, {31'd0, e_r});
    chk({tag, ":x_ovf"}, {31'd0, x_ovf}, {31'd0, e_xo});
    chk({tag, ":y_ovf"}, {31'd0, y_ovf}, {31'd0, e_yo});
    chk({tag, ":dx"}, {23'd0, dx}, e_dx & 32'h1FF);
    chk({tag, ":dy"}, {23'd0, dy}, e_dy & 32'h1FF);
  endtask

  // et: 0 good, 1 bad parity, 2 bad stop
  task automatic send_byte(input logic [7:0] data, input int et, input string tag);
    send_frame(data, et == 1, et == 2, 11);
    cycles(60);
    model_byte(data, et == 0);
    compare_all(tag);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, lat, r, et;
    logic [7:0] d;
    RST  = 1'b0;
    PS2C = 1'b1;
    PS2D = 1'b1;
    cycles(5);
    chk("rst:pkt_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst:err", {31'd0, err}, 32'd0);
    compare_all("rst");
    RST = 1'b1;
    cycles(20);

    // Basic packet
    send_byte(8'h29, 0, "p1b0");
    send_byte(8'h05, 0, "p1b1");
    send_byte(8'hFB, 0, "p1b2");
    chk("basic:dx", {23'd0, dx}, 32'h005);
    chk("basic:dy", {23'd0, dy}, 32'h1FB);
    chk("basic:btn_l", {31'd0, btn_l}, 32'd1);

    // Parity error on second byte, then a clean packet
    send_byte(8'h08, 0, "par_b0");
    send_byte(8'h10, 1, "par_bad");
    send_byte(8'h1B, 0, "par_p0");
    send_byte(8'h80, 0, "par_p1");
    send_byte(8'h7F, 0, "par_p2");

    // First byte without bit3, then zero-motion packet
    send_byte(8'h00, 0, "sync_bad");
    send_byte(8'h08, 0, "zero_b0");
    send_byte(8'h00, 0, "zero_b1");
    send_byte(8'h00, 0, "zero_b2");

    // Short clock glitch while idle must be ignored
    PS2D = 1'b0;
    PS2C = 1'b0;
    cycles(FL - 1);
    PS2C = 1'b1;
    PS2D = 1'b1;
    cycles(100);
    compare_all("glitch");
    send_byte(8'hCE, 0, "gl_b0");
    send_byte(8'h33, 0, "gl_b1");
    send_byte(8'hC4, 0, "gl_b2");

    // Device stops after five data bits
    e0 = err_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 6);
    for (int i = 0; i < TO + 200 && err_cnt == e0; i++) cycles(1);
    chk("tout:seen", err_cnt - e0, 32'd1);
    lat = err_cyc - last_fall_cyc;
    chk("tout:latency_window", {31'd0, (lat >= TO && lat <= TO + FL + 8)}, 32'd1);
    model_byte(8'hA5, 1'b0);
    cycles(60);
    compare_all("tout");
    send_byte(8'h39, 0, "to_b0");
    send_byte(8'h01, 0, "to_b1");
    send_byte(8'hFF, 0, "to_b2");

    // Reset pulse in the middle of the second byte
    send_byte(8'h08, 0, "rs_b0");
    send_frame(8'h3C, 1'b0, 1'b0, 5);
    RST = 1'b0;
    cycles(1);
    RST = 1'b1;
    q.delete();
    {e_l, e_m, e_r, e_xo, e_yo} = 5'd0;
    e_dx = 0;
    e_dy = 0;
    cycles(2);
    compare_all("rst_mid");
    cycles(TO + 50);
    compare_all("rst_quiet");
    send_byte(8'h1F, 0, "rs_p0");
    send_byte(8'h80, 0, "rs_p1");
    send_byte(8'h7F, 0, "rs_p2");

    // Random byte stream with occasional framing faults
    for (int i = 0; i < 36; i++) begin
      d = 8'($urandom);
      if (q.size() == 0 && $urandom_range(0, 4) != 0) d[3] = 1'b1;
      r = $urandom_range(0, 9);
      et = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      send_byte(d, et, "rand");
    end

    chk("err_pkt_overlap", both_cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
